// File: rtl/fetch_queue.sv
// Instruction prefetch byte queue: 16-byte ring fed by 8-byte I-cache chunks, 5-byte head window to IF/ID.
// Optional starvation counter is built only when FETCHQ_STARVE_CNT_EN is defined.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_addr,
  output logic        fetch_ready,
  input  logic        fetch_valid,
  input  logic [63:0] fetch_data,
  input  logic [2:0]  len_in,
  input  logic        stall,
  output logic [39:0] instr_out,
  output logic [31:0] pc_out,
  output logic [2:0]  instr_length_out,
  output logic        valid_out,
  output logic        bad_len_out,
  output logic [31:0] starve_cnt
);
  localparam int DEPTH = 16;
  localparam int CHUNK = 8;
  localparam int WIN   = 5;

  logic [DEPTH-1:0][7:0] ring;
  logic [3:0]  head;
  logic [4:0]  count;
  logic [2:0]  drop;
  logic [31:0] fa, pc;

  logic        len_ok, accept, deq;
  logic [4:0]  len5, add5, cnt_nxt;
  logic [3:0]  wr_base;

  assign len5        = {2'b00, len_in};
  assign len_ok      = (len_in >= 3'd1) && (len_in <= 3'd5);
  assign valid_out   = len_ok && (count >= len5);
  assign bad_len_out = !len_ok && (count != 5'd0);
  assign instr_length_out = valid_out ? len_in : 3'd0;
  assign fetch_ready = (count <= 5'd8);
  assign accept      = fetch_valid && fetch_ready && !redirect;
  assign deq         = valid_out && !stall;
  assign add5        = accept ? (5'd8 - {2'b00, drop}) : 5'd0;
  assign cnt_nxt     = count + add5 - (deq ? len5 : 5'd0);
  // count <= 8 whenever a chunk is accepted, so its low nibble is the exact tail offset
  assign wr_base     = head + count[3:0] - {1'b0, drop};

  assign fetch_addr = fa;
  assign pc_out     = pc;

  for (genvar b = 0; b < WIN; b++) begin : g_win
    logic [3:0] idx;
    assign idx = head + 4'(b);
    assign instr_out[8*b +: 8] = (count > 5'(b)) ? ring[idx] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst && accept) begin
      for (int i = 0; i < CHUNK; i++)
        if (3'(i) >= drop) ring[wr_base + 4'(i)] <= fetch_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= 4'd0;
      count <= 5'd0;
      drop  <= RESET_PC[2:0];
      fa    <= {RESET_PC[31:3], 3'b000};
      pc    <= RESET_PC;
    end else if (redirect) begin
      head  <= 4'd0;
      count <= 5'd0;
      drop  <= redirect_pc[2:0];
      fa    <= {redirect_pc[31:3], 3'b000};
      pc    <= redirect_pc;
    end else begin
      count <= cnt_nxt;
      if (deq) begin
        head <= head + {1'b0, len_in};
        pc   <= pc + {29'd0, len_in};
      end
      if (accept) begin
        drop <= 3'd0;
        fa   <= fa + 32'd8;
      end
    end
  end

`ifdef FETCHQ_STARVE_CNT_EN
  logic [31:0] starve_q;
  always_ff @(posedge clk) begin
    if (!rst)
      starve_q <= 32'd0;
    else if (!stall && !valid_out && (starve_q != 32'hFFFF_FFFF))
      starve_q <= starve_q + 32'd1;
  end
  assign starve_cnt = starve_q;
`else
  assign starve_cnt = 32'h0;
`endif
endmodule
